// File: rtl/pv_sampler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pv_sampler
//
// Purpose:
//   Paces conversions of an input-only SPI master at a fixed sample period.
//   Each completed SPI word is captured as the process variable (pv). The
//   signed error sp - pv is computed alongside it, and the pair is handed to
//   the PID core over a valid/ready handshake. A sample tick that arrives
//   while a previous sample is still in flight is dropped, and the sticky
//   overrun flag is raised.
//
// Parameters:
//   BITS    width of the SPI word, pv and sp (must match the SPI master)
//   PERIOD  clock cycles between sample ticks (>= 2)
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   sp         in   setpoint, unsigned, sampled in the CAPTURE cycle
//   spi_cs     in   SPI chip-select, active-low (low = transaction running)
//   spi_data   in   SPI parallel word, valid once spi_cs is back high
//   spi_start  out  transaction request to the SPI master
//   pv         out  last captured process variable, unsigned
//   err        out  sp - pv, BITS+1 bit two's complement
//   out_valid  out  pv/err hold a new sample
//   out_ready  in   consumer accepts the sample
//   overrun    out  sticky: a sample tick was dropped
//
// Optional feature (macro PV_SAMPLER_AVG_EN):
//   When defined, pv is the floor average of the current raw word and the
//   previous raw word. The first capture after reset uses the raw word.
// -----------------------------------------------------------------------------
module pv_sampler #(
  parameter int BITS   = 4,
  parameter int PERIOD = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] sp,
  input  logic            spi_cs,
  input  logic [BITS-1:0] spi_data,
  output logic            spi_start,
  output logic [BITS-1:0] pv,
  output logic [BITS:0]   err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            overrun
);

  localparam int            CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DONE,
    CAPTURE,
    HOLD
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   tick_cnt_reg;
  logic            tick;
  logic [BITS-1:0] pv_reg;
  logic [BITS:0]   err_reg;
  logic            out_valid_reg;
  logic            overrun_reg;
  logic [BITS-1:0] capture_pv;

  // Free-running down-counter. Reset loads PERIOD-1, so the first tick
  // lands PERIOD cycles after reset is released.
  assign tick = (tick_cnt_reg == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_reg <= RELOAD;
    end else if (tick) begin
      tick_cnt_reg <= RELOAD;
    end else begin
      tick_cnt_reg <= tick_cnt_reg - 1'b1;
    end
  end

`ifdef PV_SAMPLER_AVG_EN
  logic [BITS-1:0] prev_reg;
  logic            have_prev_reg;
  logic [BITS:0]   avg_sum;

  // The sum is one bit wider than the operands, so dropping its LSB gives
  // the floor average without losing the carry.
  assign avg_sum    = {1'b0, spi_data} + {1'b0, prev_reg};
  assign capture_pv = have_prev_reg ? avg_sum[BITS:1] : spi_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg      <= '0;
      have_prev_reg <= 1'b0;
    end else if (state_reg == CAPTURE) begin
      prev_reg      <= spi_data;
      have_prev_reg <= 1'b1;
    end
  end
`else
  assign capture_pv = spi_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      pv_reg        <= '0;
      err_reg       <= '0;
      out_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      // A tick can only start a sample from IDLE. A tick seen in any other
      // state is lost, including the HOLD cycle that returns to IDLE.
      if (tick && (state_reg != IDLE)) begin
        overrun_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (tick) begin
            state_reg <= REQ;
          end
        end
        REQ: begin
          // Keep requesting until the master acknowledges by dropping cs.
          if (!spi_cs) begin
            state_reg <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (spi_cs) begin
            state_reg <= CAPTURE;
          end
        end
        CAPTURE: begin
          pv_reg        <= capture_pv;
          err_reg       <= {1'b0, sp} - {1'b0, capture_pv};
          out_valid_reg <= 1'b1;
          state_reg     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign spi_start = (state_reg == REQ);
  assign pv        = pv_reg;
  assign err       = err_reg;
  assign out_valid = out_valid_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_pv_sampler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_pv_sampler
//
// Self-checking bench for pv_sampler (BITS=4, PERIOD=16). A behavioural SPI
// master answers spi_start: it pulls cs low after a programmable delay, keeps
// it low for 8 cycles, and then raises it together with the next data word.
// At that moment it pushes the expected pv/err onto a scoreboard. The
// samples are popped and compared when the DUT presents them.
// -----------------------------------------------------------------------------
module tb_pv_sampler;

  localparam int BITS   = 4;
  localparam int PERIOD = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [BITS-1:0] sp = '0;
  logic            spi_cs = 1'b1;
  logic [BITS-1:0] spi_data = '0;
  logic            spi_start;
  logic [BITS-1:0] pv;
  logic [BITS:0]   err;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            overrun;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int              fall_delay = 0;
  logic [BITS-1:0] next_data = '0;
  logic [BITS-1:0] exp_pv_q[$];
  logic [BITS:0]   exp_err_q[$];

  pv_sampler #(
    .BITS   (BITS),
    .PERIOD (PERIOD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sp        (sp),
    .spi_cs    (spi_cs),
    .spi_data  (spi_data),
    .spi_start (spi_start),
    .pv        (pv),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural SPI master, evaluated on the falling edge.
  initial begin : spi_model
    int              phase;
    int              cnt;
    logic [BITS-1:0] model_prev;
    logic            model_have;
    logic [BITS:0]   sum;
    logic [BITS-1:0] epv;
    phase      = 0;
    cnt        = 0;
    model_prev = '0;
    model_have = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        spi_cs     = 1'b1;
        phase      = 0;
        model_prev = '0;
        model_have = 1'b0;
      end else begin
        case (phase)
          0: if (spi_start === 1'b1) begin
            if (fall_delay == 0) begin
              spi_cs = 1'b0;
              cnt    = 8;
              phase  = 2;
            end else begin
              cnt   = fall_delay;
              phase = 1;
            end
          end
          1: begin
            cnt--;
            if (cnt == 0) begin
              spi_cs = 1'b0;
              cnt    = 8;
              phase  = 2;
            end
          end
          default: begin
            cnt--;
            if (cnt == 0) begin
              spi_cs   = 1'b1;
              spi_data = next_data;
`ifdef PV_SAMPLER_AVG_EN
              if (model_have) begin
                sum = {1'b0, next_data} + {1'b0, model_prev};
                epv = sum[BITS:1];
              end else begin
                epv = next_data;
              end
`else
              epv = next_data;
`endif
              model_prev = next_data;
              model_have = 1'b1;
              exp_pv_q.push_back(epv);
              exp_err_q.push_back({1'b0, sp} - {1'b0, epv});
              phase = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic wait_start(output int at);
    int n = 0;
    while (spi_start !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (spi_start !== 1'b1) check("start_timeout", 32'd0, 32'd1);
    at = cyc;
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (out_valid !== 1'b1) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic score_sample(input string tag);
    logic [BITS-1:0] epv;
    logic [BITS:0]   eerr;
    if (exp_pv_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      epv  = exp_pv_q.pop_front();
      eerr = exp_err_q.pop_front();
      $display("sample %s: sp=%h pv=%h err=%h (expected pv=%h err=%h)",
               tag, sp, pv, err, epv, eerr);
      check({tag, "_pv"}, 32'(pv), 32'(epv));
      check({tag, "_err"}, 32'(err), 32'(eerr));
    end
  endtask

  // Waits for a sample with out_ready high, then checks it and that
  // out_valid lasts a single cycle.
  task automatic wait_xfer(input string tag);
    wait_valid();
    score_sample(tag);
    @(negedge clk);
    check({tag, "_valid_1cyc"}, 32'(out_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : main
    int              t0, t1, t3, t4, n, rel;
    logic [BITS-1:0] hpv;
    logic [BITS:0]   herr;

    // Reset state
    reset     = 1'b1;
    sp        = 4'h5;
    next_data = 4'hA;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_spi_start", 32'(spi_start), 32'd0);
    check("rst_pv", 32'(pv), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    rel   = cyc;

    // A: sp=5, data=A, which gives err=-5
    wait_start(t0);
    check("first_start_cycle", 32'(t0 - rel), 32'd16);
    wait_xfer("A");
    check("A_pv_const", 32'(pv), 32'h0A);
    check("A_err_const", 32'(err), 32'h1B);
    check("A_overrun", 32'(overrun), 32'd0);

    // B: sp=F, data=0
    sp        = 4'hF;
    next_data = 4'h0;
    wait_start(t1);
    check("B_period", 32'(t1 - t0), 32'd16);
    wait_xfer("B");
`ifndef PV_SAMPLER_AVG_EN
    check("B_err_const", 32'(err), 32'h0F);
`endif

    // B2: sp=0, data=F, which gives err=-15
    sp        = 4'h0;
    next_data = 4'hF;
    wait_start(t1);
    wait_xfer("B2");
`ifndef PV_SAMPLER_AVG_EN
    check("B2_err_const", 32'(err), 32'h11);
`endif

    // D: cs fall delayed 5 cycles. The transaction then ends in HOLD exactly
    // on the next tick, so that tick is dropped.
    sp         = 4'h5;
    next_data  = 4'h6;
    fall_delay = 5;
    wait_start(t3);
    check("D_overrun_before", 32'(overrun), 32'd0);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (spi_start === 1'b1) n++;
      else break;
    end
    check("D_start_high_cycles", 32'(n), 32'd6);
    wait_xfer("D");
    check("D_overrun_after", 32'(overrun), 32'd1);
    fall_delay = 0;
    next_data  = 4'h4;
    wait_start(t4);
    check("D_next_start_gap", 32'(t4 - t3), 32'd32);
    wait_xfer("D2");

    // C: consumer stalls for 40 cycles
    do_reset();
    rel       = cyc;
    sp        = 4'h5;
    next_data = 4'h7;
    out_ready = 1'b0;
    wait_start(t0);
    check("C_start_cycle", 32'(t0 - rel), 32'd16);
    wait_valid();
    check("C_overrun_before", 32'(overrun), 32'd0);
    hpv  = pv;
    herr = err;
    check("C_pv_const", 32'(hpv), 32'h07);
    check("C_err_const", 32'(herr), 32'h1E);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("C_hold_valid", 32'(out_valid), 32'd1);
      check("C_hold_pv", 32'(pv), 32'(hpv));
      check("C_hold_err", 32'(err), 32'(herr));
    end
    check("C_overrun_after", 32'(overrun), 32'd1);
    out_ready = 1'b1;
    score_sample("C");
    @(negedge clk);
    check("C_valid_drop", 32'(out_valid), 32'd0);
    next_data = 4'h9;
    wait_start(t1);
    check("C_next_start_on_tick", 32'((t1 - t0) % PERIOD), 32'd0);
    wait_xfer("C2");

    // E: reset while waiting for the SPI word
    next_data = 4'h3;
    wait_start(t1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("E_spi_start", 32'(spi_start), 32'd0);
    check("E_out_valid", 32'(out_valid), 32'd0);
    check("E_pv", 32'(pv), 32'd0);
    check("E_err", 32'(err), 32'd0);
    check("E_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rel   = cyc;
    next_data = 4'h2;
    wait_start(t1);
    check("E_restart_cycle", 32'(t1 - rel), 32'd16);
    wait_xfer("E");

    // F: data 8 then 3 after reset (averaged when enabled)
    do_reset();
    next_data = 4'h8;
    wait_start(t1);
    wait_xfer("F1");
    check("F1_pv_const", 32'(pv), 32'h08);
    next_data = 4'h3;
    wait_start(t1);
    wait_xfer("F2");
`ifdef PV_SAMPLER_AVG_EN
    check("F2_pv_const", 32'(pv), 32'h05);
`else
    check("F2_pv_const", 32'(pv), 32'h03);
`endif

    check("sb_drained", 32'(exp_pv_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
